// File: rtl/apb_uart_tx_slave_if.sv
// APB bus bundle for apb_uart_tx_slave.
//   psel/penable/pwrite/paddr/pwdata : master -> slave request
//   prdata/pready/pslverr            : slave -> master response
interface apb_uart_tx_slave_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [4:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_uart_tx_slave.sv
// APB slave UART transmitter: bytes written to TXDATA are queued in a FIFO
// and serialised 8N1, LSB first, on o_tx.
//   i_pclk    : APB/system clock, rising edge
//   i_reset   : asynchronous active-high reset
//   s_apb     : APB slave port (zero wait states, pready tied 1)
//   o_tx      : serial output, idle high
//   o_tx_busy : frame on the line or FIFO non-empty
// Registers: 0 TXDATA (W), 1 STATUS (R), 2 CTRL (R/W, bit0 tx_en).
module apb_uart_tx_slave #(
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic                 i_pclk,
  input  logic                 i_reset,
  apb_uart_tx_slave_if.slave   s_apb,
  output logic                 o_tx,
  output logic                 o_tx_busy
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned BAUD_W = 16;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam logic [4:0] A_TXDATA = 5'd0;
  localparam logic [4:0] A_STATUS = 5'd1;
  localparam logic [4:0] A_CTRL   = 5'd2;

  logic [7:0]        r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_tx_en;

  logic [1:0]        r_state;
  logic [BAUD_W-1:0] r_baud;
  logic [2:0]        r_bitcnt;
  logic [7:0]        r_shift;
  logic              r_tx;

  logic              w_access;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_baud_end;
  logic [4:0]        w_count5;
  logic [31:0]       w_status;
  logic [31:0]       w_prdata;
  logic              w_pslverr;
  logic              w_unused;

  assign w_access   = s_apb.psel & s_apb.penable;
  // Full/empty come from the registered count, so a pop on the same edge
  // never makes room for a push against a full FIFO.
  assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_push     = w_access & s_apb.pwrite & (s_apb.paddr == A_TXDATA) & ~w_full;
  assign w_baud_end = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));
  // Pops happen from IDLE, or at the end of STOP to chain frames without an idle bit.
  assign w_pop      = r_tx_en & ~w_empty &
                      ((r_state == S_IDLE) | ((r_state == S_STOP) & w_baud_end));

  assign w_count5   = 5'(r_count);
  assign w_status   = {23'd0, w_count5, 1'b0, w_empty, w_full, o_tx_busy};
  assign w_unused   = ^s_apb.pwdata[31:8];

  always_comb begin
    w_prdata  = '0;
    w_pslverr = 1'b0;
    if (w_access) begin
      case (s_apb.paddr)
        A_TXDATA: w_pslverr = s_apb.pwrite & w_full;
        A_STATUS: w_prdata  = w_status;
        A_CTRL:   w_prdata  = {31'd0, r_tx_en};
        default:  w_pslverr = 1'b1;
      endcase
    end
  end

  assign s_apb.prdata  = w_prdata;
  assign s_apb.pslverr = w_pslverr;
  assign s_apb.pready  = 1'b1;

  always_ff @(posedge i_pclk or posedge i_reset) begin
    if (i_reset) begin
      r_tx_en <= 1'b1;
    end else if (w_access & s_apb.pwrite & (s_apb.paddr == A_CTRL)) begin
      r_tx_en <= s_apb.pwdata[0];
    end
  end

  always_ff @(posedge i_pclk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= s_apb.pwdata[7:0];
    end
  end

  always_ff @(posedge i_pclk or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // tx is registered: each transition loads the level of the state being entered.
  always_ff @(posedge i_pclk or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_baud   <= '0;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_tx     <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx   <= 1'b1;
          r_baud <= '0;
          if (w_pop) begin
            r_shift  <= r_mem[r_rd_ptr];
            r_bitcnt <= '0;
            r_state  <= S_START;
            r_tx     <= 1'b0;
          end
        end
        S_START: begin
          if (w_baud_end) begin
            r_baud  <= '0;
            r_state <= S_DATA;
            r_tx    <= r_shift[0];
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_DATA: begin
          if (w_baud_end) begin
            r_baud <= '0;
            if (r_bitcnt == 3'd7) begin
              r_state <= S_STOP;
              r_tx    <= 1'b1;
            end else begin
              r_shift  <= {1'b0, r_shift[7:1]};
              r_bitcnt <= r_bitcnt + 1'b1;
              r_tx     <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: begin
          if (w_baud_end) begin
            r_baud <= '0;
            if (w_pop) begin
              r_shift  <= r_mem[r_rd_ptr];
              r_bitcnt <= '0;
              r_state  <= S_START;
              r_tx     <= 1'b0;
            end else begin
              r_state <= S_IDLE;
              r_tx    <= 1'b1;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
      endcase
    end
  end

  assign o_tx      = r_tx;
  assign o_tx_busy = (r_state != S_IDLE) | ~w_empty;

endmodule
